// File: rtl/prince_pkg.sv
// Shared PRINCE constants and key-schedule controller state encoding.
package prince_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXTEND = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

  function automatic logic [63:0] rc(input logic [3:0] i);
    case (i)
      4'd0:    rc = 64'h0000000000000000;
      4'd1:    rc = 64'h13198a2e03707344;
      4'd2:    rc = 64'ha4093822299f31d0;
      4'd3:    rc = 64'h082efa98ec4e6c89;
      4'd4:    rc = 64'h452821e638d01377;
      4'd5:    rc = 64'hbe5466cf34e90c6c;
      4'd6:    rc = 64'h7ef84f78fd955cb1;
      4'd7:    rc = 64'h85840851f1ac43aa;
      4'd8:    rc = 64'hc882d32f25323c54;
      4'd9:    rc = 64'h64a51195e0e3610d;
      4'd10:   rc = 64'hd3b5a399ca0c2399;
      4'd11:   rc = 64'hc0ac29b7c97c50dd;
      default: rc = 64'h0000000000000000;
    endcase
  endfunction

endpackage

// File: rtl/prince_keyextend.sv
// Per-share PRINCE key extension: splits k0/k1 and derives k0' (linear, so share-wise safe).
module prince_keyextend (
  input  logic [127:0] key,
  output logic [63:0]  k0,
  output logic [63:0]  k0p,
  output logic [63:0]  k1
);

  assign k0  = key[127:64];
  assign k1  = key[63:0];
  assign k0p = {key[64], key[127:65]} ^ {63'b0, key[127]};

endmodule

// File: rtl/prince_key_sched_ctrl.sv
// Masked PRINCE key-schedule sequencer: accepts a shared key, extends it and
// streams 14 round-key slots with alpha-reflection for decryption.
module prince_key_sched_ctrl
  import prince_pkg::*;
#(
  parameter int NSHARES = 5,
  parameter int NSLOTS  = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSHARES*128-1:0] key_in,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic                   decrypt,
  output logic [NSHARES*64-1:0]  rk_out,
  output logic [3:0]             rk_idx,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic                   rk_last,
  output logic                   busy
);

  localparam logic [3:0] LAST = 4'(NSLOTS - 1);

  state_t                  state;
  logic [NSHARES*128-1:0]  key_p0;
  logic                    dec_p0;
  logic [NSHARES*64-1:0]   k0_p1, k0p_p1, k1_p1;
  logic [NSHARES*64-1:0]   k0_x, k0p_x, k1_x;
  logic                    hs;

  assign hs = rk_valid & rk_ready;

  for (genvar g = 0; g < NSHARES; g++) begin : g_ext
    prince_keyextend u_ext (
      .key (key_p0[g*128 +: 128]),
      .k0  (k0_x[g*64 +: 64]),
      .k0p (k0p_x[g*64 +: 64]),
      .k1  (k1_x[g*64 +: 64])
    );
  end

  // Public constants touch share 0 only; other shares carry the plain key words.
  function automatic logic [NSHARES*64-1:0] slot_word(
    input logic [3:0]              idx,
    input logic                    dec,
    input logic [NSHARES*64-1:0]   k0,
    input logic [NSHARES*64-1:0]   k0p,
    input logic [NSHARES*64-1:0]   k1
  );
    logic [NSHARES*64-1:0] w;
    if (idx == 4'd0) begin
      w = dec ? k0p : k0;
    end else if (idx == LAST) begin
      w = dec ? k0 : k0p;
    end else begin
      w = k1;
      w[63:0] = k1[63:0] ^ rc(idx - 4'd1) ^ (dec ? ALPHA : 64'h0);
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      key_p0    <= '0;
      dec_p0    <= 1'b0;
      k0_p1     <= '0;
      k0p_p1    <= '0;
      k1_p1     <= '0;
      rk_out    <= '0;
      rk_idx    <= 4'd0;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
    end else begin
      case (state)
        // p0: capture the shared key and mode
        ST_IDLE: begin
          if (!key_ready) begin
            key_ready <= 1'b1;
          end else if (key_valid) begin
            key_p0    <= key_in;
            dec_p0    <= decrypt;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_EXTEND;
          end
        end
        // p1: register extended key words and present slot 0
        ST_EXTEND: begin
          k0_p1    <= k0_x;
          k0p_p1   <= k0p_x;
          k1_p1    <= k1_x;
          key_p0   <= '0;
          rk_out   <= slot_word(4'd0, dec_p0, k0_x, k0p_x, k1_x);
          rk_idx   <= 4'd0;
          rk_last  <= 1'b0;
          rk_valid <= 1'b1;
          state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (hs) begin
            if (rk_idx == LAST) begin
              k0_p1     <= '0;
              k0p_p1    <= '0;
              k1_p1     <= '0;
              dec_p0    <= 1'b0;
              rk_out    <= '0;
              rk_idx    <= 4'd0;
              rk_last   <= 1'b0;
              rk_valid  <= 1'b0;
              busy      <= 1'b0;
              key_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              rk_out  <= slot_word(rk_idx + 4'd1, dec_p0, k0_p1, k0p_p1, k1_p1);
              rk_idx  <= rk_idx + 4'd1;
              rk_last <= ((rk_idx + 4'd1) == LAST);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_key_sched_ctrl.sv
// Directed and randomized bench for the masked PRINCE key-schedule sequencer.
module tb_prince_key_sched_ctrl;

  localparam int NS = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NS*128-1:0] key_in = '0;
  logic            key_valid = 1'b0;
  logic            key_ready;
  logic            decrypt = 1'b0;
  logic [NS*64-1:0] rk_out;
  logic [3:0]      rk_idx;
  logic            rk_valid;
  logic            rk_ready = 1'b0;
  logic            rk_last;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [NS*64-1:0] got [14];

  localparam logic [63:0] ALPHA_C = 64'hc0ac29b7c97c50dd;
  logic [63:0] rct [12] = '{
    64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
    64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
    64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
    64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};

  prince_key_sched_ctrl #(.NSHARES(NS), .NSLOTS(14)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .decrypt(decrypt), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NS*64-1:0] obs, input logic [NS*64-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference schedule for one unshared 128-bit key; pub selects whether constants apply.
  function automatic logic [63:0] uk_slot(input logic [127:0] k, input logic dec, input int n, input bit pub);
    logic [63:0] k0, k1, k0p, c;
    k0  = k[127:64];
    k1  = k[63:0];
    k0p = ((k0 >> 1) | (k0 << 63)) ^ (k0 >> 63);
    if (n == 0) return dec ? k0p : k0;
    if (n == 13) return dec ? k0 : k0p;
    c = pub ? (rct[n-1] ^ (dec ? ALPHA_C : 64'h0)) : 64'h0;
    return k1 ^ c;
  endfunction

  function automatic logic [NS*64-1:0] exp_slot(input logic [NS*128-1:0] key, input logic dec, input int n);
    logic [NS*64-1:0] w;
    for (int s = 0; s < NS; s++) w[s*64 +: 64] = uk_slot(key[s*128 +: 128], dec, n, s == 0);
    return w;
  endfunction

  function automatic logic [127:0] unmask(input logic [NS*128-1:0] key);
    logic [127:0] k = '0;
    for (int s = 0; s < NS; s++) k ^= key[s*128 +: 128];
    return k;
  endfunction

  function automatic logic [63:0] xor_shares(input logic [NS*64-1:0] w);
    logic [63:0] x = '0;
    for (int s = 0; s < NS; s++) x ^= w[s*64 +: 64];
    return x;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NS*128-1:0] rndkey();
    logic [NS*128-1:0] k;
    for (int s = 0; s < NS; s++) k[s*128 +: 128] = rnd128();
    return k;
  endfunction

  task automatic run_stream(input logic [NS*128-1:0] key, input logic dec, input bit rnd_rdy,
                            input bit pulse_kv, input int abort_at, input bit xor_chk);
    int n;
    int budget;
    budget = 0;
    while (!key_ready && budget < 20) begin
      tick;
      budget++;
    end
    chk("key_ready_wait", key_ready, 1);
    key_in = key; decrypt = dec; key_valid = 1'b1; rk_ready = 1'b0;
    tick;
    key_valid = 1'b0; key_in = rndkey(); decrypt = ~dec;
    chk("extend_flags", {busy, key_ready, rk_valid}, 3'b100);
    tick;
    chk("first_valid", rk_valid, 1);
    n = 0; budget = 0;
    while (n < 14 && budget < 400) begin
      budget++;
      chk("rk_valid_run", rk_valid, 1);
      chk("rk_idx", rk_idx, n);
      chk("rk_out", rk_out, exp_slot(key, dec, n));
      chk("rk_last", rk_last, n == 13);
      chk("busy_run", {busy, key_ready}, 2'b10);
      if (xor_chk) chk("xor_unmasked", xor_shares(rk_out), uk_slot(unmask(key), dec, n, 1'b1));
      got[n] = rk_out;
      if (n == abort_at) return;
      rk_ready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid = (pulse_kv && n < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pulse_kv) begin
        key_in  = rndkey();
        decrypt = 1'($urandom_range(0, 1));
      end
      tick;
      if (rk_ready) n++;
    end
    rk_ready = 1'b0; key_valid = 1'b0;
    chk("slot_count", n, 14);
    chk("post_flags", {rk_valid, rk_last, busy, key_ready}, 4'b0001);
    chk("post_zero", {rk_out, rk_idx}, '0);
  endtask

  initial begin
    logic [NS*128-1:0] k;
    logic [127:0] kk;

    #1 rst_n = 1'b0;
    #3;
    chk("reset_flags", {key_ready, rk_valid, rk_last, busy}, 4'b0000);
    chk("reset_out", {rk_out, rk_idx}, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick;
    chk("ready_after_reset", key_ready, 1);

    // all-zero key, encrypt
    run_stream('0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("zero_slot0", got[0], '0);
    chk("zero_slot1", got[1], '0);
    chk("zero_slot2", got[2], {256'h0, 64'h13198a2e03707344});
    chk("zero_slot13", got[13], '0);

    // share0 k0 all ones
    k = '0;
    k[127:64] = 64'hffffffffffffffff;
    run_stream(k, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("ones_slot0", got[0], {256'h0, 64'hffffffffffffffff});
    chk("ones_slot13", got[13], {256'h0, 64'hfffffffffffffffe});
    chk("ones_slot12", got[12], {256'h0, 64'hc0ac29b7c97c50dd});

    // all-zero key, decrypt
    run_stream('0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    chk("dec_slot1", got[1], {256'h0, 64'hc0ac29b7c97c50dd});
    chk("dec_slot12", got[12], '0);

    // masked keys, random backpressure and ignored key_valid pulses
    for (int r = 0; r < 4; r++) begin
      kk = rnd128();
      k = rndkey();
      k[127:0] = kk ^ k[255:128] ^ k[383:256] ^ k[511:384] ^ k[639:512];
      run_stream(k, 1'(r), 1'b1, 1'b1, -1, 1'b1);
    end

    // reset mid-stream at slot 6
    run_stream(rndkey(), 1'b0, 1'b0, 1'b0, 6, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {key_ready, rk_valid, rk_last, busy}, 4'b0000);
    chk("midrst_out", {rk_out, rk_idx}, '0);
    rk_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick;
    chk("midrst_ready", key_ready, 1);
    run_stream(rndkey(), 1'b1, 1'b1, 1'b0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
